// File: rtl/scarv_ccx_mmio_timers_if.sv
// Simple request/response memory interface shared by CCX peripherals.
interface scarv_ccx_memif;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, strb, addr, wdata, input  gnt, rdata, error);
    modport RSP (input  req, wen, strb, addr, wdata, output gnt, rdata, error);
endinterface

// File: rtl/scarv_ccx_mmio_timers.sv
// Memory-mapped 64-bit mtime counter with prescaler and NCMP compare channels,
// each raising a registered timer interrupt when mtime >= its MTIMECMP.
module scarv_ccx_mmio_timers #(
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] MMIO_SIZE      = 32'h0000_0100,
    parameter int          NCMP           = 2,
    parameter int          PRESCALE_W     = 8,
    parameter logic [63:0] MTIMECMP_RESET = '1
)(
    input  logic             f_clk,
    input  logic             g_resetn,
    scarv_ccx_memif.RSP      mmio,
    output logic [NCMP-1:0]  timer_interrupt,
    output logic [63:0]      ctr_time
);

    localparam int AW = $clog2(MMIO_SIZE);
    localparam int IW = AW - 2;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++) merge[8*b +: 8] = s[b] ? wd[8*b +: 8] : old[8*b +: 8];
    endfunction

    logic [63:0]           mtime;
    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] prescale;
    logic                  en;
    logic [NCMP-1:0]       irq_en;
    logic [31:0]           shadow;
    logic [31:0]           rdata_q;
    logic                  error_q;
    logic [63:0]           cmp_val [NCMP];

    logic [IW-1:0] idx;
    logic          wr, rd, tick;
    logic [31:0]   ctrl_word, irq_word, ctrl_new, irq_new, wr_half;
    logic [31:0]   rd_val;
    logic          mapped;

    // Only the in-window word offset participates in decode.
    assign idx       = mmio.addr[AW-1:2];
    assign wr        = mmio.req &&  mmio.wen;
    assign rd        = mmio.req && !mmio.wen;
    assign tick      = en && (pre_q == prescale);
    assign ctrl_word = 32'({prescale, 7'b0, en});
    assign irq_word  = 32'(irq_en);
    assign ctrl_new  = merge(ctrl_word, mmio.wdata, mmio.strb);
    assign irq_new   = merge(irq_word,  mmio.wdata, mmio.strb);
    assign wr_half   = merge(idx == IW'(1) ? mtime[63:32] : mtime[31:0], mmio.wdata, mmio.strb);

    logic unused_bits;
    assign unused_bits = ^{mmio.addr[31:AW], mmio.addr[1:0], MMIO_BASE_ADDR, ctrl_new, irq_new};

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        if      (idx == IW'(0)) begin rd_val = mtime[31:0]; mapped = 1'b1; end
        else if (idx == IW'(1)) begin rd_val = shadow;      mapped = 1'b1; end
        else if (idx == IW'(2)) begin rd_val = ctrl_word;   mapped = 1'b1; end
        else if (idx == IW'(3)) begin rd_val = irq_word;    mapped = 1'b1; end
        for (int i = 0; i < NCMP; i++) begin
            if (idx == IW'(4 + 2*i)) begin rd_val = cmp_val[i][31:0];  mapped = 1'b1; end
            if (idx == IW'(5 + 2*i)) begin rd_val = cmp_val[i][63:32]; mapped = 1'b1; end
        end
    end

    always_ff @(posedge f_clk) begin
        if (!g_resetn) begin
            mtime    <= '0;
            pre_q    <= '0;
            shadow   <= '0;
            en       <= 1'b1;
            prescale <= '0;
            irq_en   <= '1;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            // A software write to mtime takes precedence over the tick.
            if (wr && idx == IW'(0))      mtime[31:0]  <= wr_half;
            else if (wr && idx == IW'(1)) mtime[63:32] <= wr_half;
            else if (tick)                mtime        <= mtime + 64'd1;

            if (wr && idx == IW'(2))      pre_q <= '0;
            else if (en)                  pre_q <= tick ? '0 : pre_q + 1'b1;

            if (rd && idx == IW'(0))      shadow <= mtime[63:32];
            else if (wr && idx == IW'(1)) shadow <= wr_half;

            if (wr && idx == IW'(2)) begin
                en       <= ctrl_new[0];
                prescale <= ctrl_new[8 +: PRESCALE_W];
            end
            if (wr && idx == IW'(3)) irq_en <= irq_new[NCMP-1:0];

            if (mmio.req) begin
                rdata_q <= mapped ? rd_val : 32'h0;
                error_q <= !mapped;
            end
        end
    end

    for (genvar i = 0; i < NCMP; i++) begin : g_cmp
        logic [63:0] cmp_q;
        logic        irq_q;
        always_ff @(posedge f_clk) begin
            if (!g_resetn) begin
                cmp_q <= MTIMECMP_RESET;
                irq_q <= 1'b0;
            end else begin
                if (wr && idx == IW'(4 + 2*i)) cmp_q[31:0]  <= merge(cmp_q[31:0],  mmio.wdata, mmio.strb);
                if (wr && idx == IW'(5 + 2*i)) cmp_q[63:32] <= merge(cmp_q[63:32], mmio.wdata, mmio.strb);
                irq_q <= irq_en[i] && (mtime >= cmp_q);
            end
        end
        assign cmp_val[i]         = cmp_q;
        assign timer_interrupt[i] = irq_q;
    end

    assign mmio.gnt   = 1'b1;
    assign mmio.rdata = rdata_q;
    assign mmio.error = error_q;
    assign ctr_time   = mtime;

endmodule

// File: tb/tb_scarv_ccx_mmio_timers.sv
// Directed checks of the MMIO timer block: counting, prescale, coherent reads, compare IRQs, decode and reset.
module tb_scarv_ccx_mmio_timers;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        f_clk;
    logic        g_resetn;
    logic [1:0]  timer_interrupt;
    logic [63:0] ctr_time;
    int          checks;
    int          errors;

    scarv_ccx_memif mmio();

    scarv_ccx_mmio_timers #(
        .MMIO_BASE_ADDR (BASE),
        .MMIO_SIZE      (32'h0000_0100),
        .NCMP           (2),
        .PRESCALE_W     (8),
        .MTIMECMP_RESET ('1)
    ) dut (
        .f_clk           (f_clk),
        .g_resetn        (g_resetn),
        .mmio            (mmio),
        .timer_interrupt (timer_interrupt),
        .ctr_time        (ctr_time)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge f_clk);
        mmio.req = 1'b1; mmio.wen = 1'b1; mmio.addr = a; mmio.wdata = d; mmio.strb = s;
        @(posedge f_clk);
        #1;
        mmio.req = 1'b0; mmio.wen = 1'b0;
    endtask

    task automatic mmio_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge f_clk);
        mmio.req = 1'b1; mmio.wen = 1'b0; mmio.addr = a; mmio.strb = 4'h0;
        @(posedge f_clk);
        #1;
        d = mmio.rdata; e = mmio.error;
        mmio.req = 1'b0;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) @(posedge f_clk);
        #1;
        checks++; if (ctr_time !== 64'd0) begin errors++; $display("FAIL reset_mtime got %h want 0", ctr_time); end
        checks++; if (timer_interrupt !== 2'b00) begin errors++; $display("FAIL reset_irq got %b want 00", timer_interrupt); end
        checks++; if (mmio.rdata !== 32'd0 || mmio.error !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b want 0/0", mmio.rdata, mmio.error); end
        checks++; if (mmio.gnt !== 1'b1) begin errors++; $display("FAIL gnt got %b want 1", mmio.gnt); end
        @(negedge f_clk);
        g_resetn = 1'b1;
        repeat (10) @(posedge f_clk);
        #1;
        checks++; if (ctr_time !== 64'd10) begin errors++; $display("FAIL freerun_10 got %0d want 10", ctr_time); end
        checks++; if (timer_interrupt !== 2'b00) begin errors++; $display("FAIL freerun_irq got %b want 00", timer_interrupt); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic        e;
        // The write edge still carries a PRESCALE=0 tick: mtime goes 10 -> 11.
        mmio_wr(BASE + 32'h08, 32'h0000_0301, 4'hF);
        checks++; if (ctr_time !== 64'd11) begin errors++; $display("FAIL prescale_start got %0d want 11", ctr_time); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge f_clk);
            #1;
            checks++;
            if (ctr_time !== 64'(11 + k/4)) begin
                errors++; $display("FAIL prescale_k%0d got %0d want %0d", k, ctr_time, 11 + k/4);
            end
        end
        mmio_rd(BASE + 32'h08, d, e);
        checks++; if (d !== 32'h0000_0301 || e !== 1'b0) begin errors++; $display("FAIL ctrl_read got %h/%b want 00000301/0", d, e); end
        mmio_wr(BASE + 32'h08, 32'hFFFF_FF01, 4'hF);
        mmio_rd(BASE + 32'h08, d, e);
        checks++; if (d !== 32'h0000_FF01) begin errors++; $display("FAIL ctrl_mask got %h want 0000ff01", d); end
        mmio_wr(BASE + 32'h08, 32'h0000_0001, 4'hF);
    endtask

    task automatic test_coherent_read();
        logic [31:0] d;
        logic        e;
        mmio_wr(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        mmio_wr(BASE + 32'h04, 32'h0000_0000, 4'hF);
        checks++; if (ctr_time !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mtime_set got %h want 00000000ffffffff", ctr_time); end
        mmio_rd(BASE + 32'h00, d, e);
        checks++; if (d !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL pair0_lo got %h want ffffffff", d); end
        mmio_rd(BASE + 32'h04, d, e);
        checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL pair0_hi got %h want 00000000", d); end
        mmio_rd(BASE + 32'h00, d, e);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL pair1_lo got %h want 00000001", d); end
        mmio_rd(BASE + 32'h04, d, e);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL pair1_hi got %h want 00000001", d); end
        @(posedge f_clk);
        #1;
        checks++; if (mmio.rdata !== 32'h0000_0001) begin errors++; $display("FAIL rdata_hold got %h want 00000001", mmio.rdata); end
    endtask

    task automatic test_compare_irq();
        mmio_wr(BASE + 32'h04, 32'h0, 4'hF);
        mmio_wr(BASE + 32'h00, 32'd90, 4'hF);
        mmio_wr(BASE + 32'h0C, 32'h2, 4'hF);
        mmio_wr(BASE + 32'h18, 32'd100, 4'hF);
        mmio_wr(BASE + 32'h1C, 32'h0, 4'hF);
        checks++; if (ctr_time !== 64'd93) begin errors++; $display("FAIL irq_start got %0d want 93", ctr_time); end
        for (int k = 1; k <= 12; k++) begin
            @(posedge f_clk);
            #1;
            checks++;
            if (ctr_time !== 64'(93 + k) || timer_interrupt !== ((92 + k >= 100) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL irq_k%0d got %0d/%b want %0d/%b", k, ctr_time, timer_interrupt,
                         93 + k, (92 + k >= 100) ? 2'b10 : 2'b00);
            end
        end
    endtask

    task automatic test_strobe();
        mmio_wr(BASE + 32'h00, 32'h1234_5678, 4'hF);
        mmio_wr(BASE + 32'h00, 32'hAAAA_5555, 4'b0011);
        checks++; if (ctr_time !== 64'h0000_0000_1234_5555) begin errors++; $display("FAIL strobe_lo got %h want 0000000012345555", ctr_time); end
        @(posedge f_clk);
        #1;
        checks++; if (ctr_time !== 64'h0000_0000_1234_5556) begin errors++; $display("FAIL strobe_next got %h want 0000000012345556", ctr_time); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        e;
        mmio_rd(32'h0000_200A, d, e);
        checks++; if (d !== 32'h0000_0001 || e !== 1'b0) begin errors++; $display("FAIL alias_ctrl got %h/%b want 00000001/0", d, e); end
        mmio_wr(BASE + 32'h20, 32'hDEAD_BEEF, 4'hF);
        checks++; if (mmio.error !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err got %b want 1", mmio.error); end
        mmio_rd(BASE + 32'h0C, d, e);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL irq_en_read got %h want 00000002", d); end
    endtask

    task automatic test_error_reset();
        logic [31:0] d;
        logic        e;
        mmio_rd(BASE + 32'hFC, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_fc got %h/%b want 00000000/1", d, e); end
        @(negedge f_clk);
        mmio.req = 1'b1; mmio.wen = 1'b0; mmio.addr = BASE; g_resetn = 1'b0;
        @(posedge f_clk);
        #1;
        mmio.req = 1'b0;
        checks++; if (mmio.rdata !== 32'h0 || mmio.error !== 1'b0) begin errors++; $display("FAIL rst_rsp got %h/%b want 0/0", mmio.rdata, mmio.error); end
        checks++; if (ctr_time !== 64'd0 || timer_interrupt !== 2'b00) begin errors++; $display("FAIL rst_state got %h/%b want 0/00", ctr_time, timer_interrupt); end
        @(negedge f_clk);
        g_resetn = 1'b1;
        mmio_rd(BASE + 32'h0C, d, e);
        checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL rst_irq_en got %h want 00000003", d); end
        mmio_rd(BASE + 32'h1C, d, e);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp1_hi got %h want ffffffff", d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        mmio.req = 1'b0; mmio.wen = 1'b0; mmio.strb = 4'h0; mmio.addr = '0; mmio.wdata = '0;
        g_resetn = 1'b0;
        test_reset();
        test_prescale();
        test_coherent_read();
        test_compare_irq();
        test_strobe();
        test_decode();
        test_error_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
